// File: rtl/data_mem_responder_if.sv
// Core RAM port plus host preload/dump handshake and status, bundled for the data-memory responder.
interface data_mem_responder_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] ADDR_RAM;
  logic [SIZE-1:0]       Q_W;
  logic                  ENABLE_W;
  logic [SIZE-1:0]       Q_RAM;
  logic                  HOST_REQ;
  logic                  HOST_WE;
  logic [ADDR_WIDTH-1:0] HOST_ADDR;
  logic [SIZE-1:0]       HOST_WDATA;
  logic                  HOST_ACK;
  logic [SIZE-1:0]       HOST_RDATA;
  logic                  MEM_READY;
  logic [CNT_WIDTH-1:0]  WRITE_COUNT;

  modport slave (
    input  ADDR_RAM, Q_W, ENABLE_W, HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    output Q_RAM, HOST_ACK, HOST_RDATA, MEM_READY, WRITE_COUNT
  );

  modport master (
    output ADDR_RAM, Q_W, ENABLE_W, HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA,
    input  Q_RAM, HOST_ACK, HOST_RDATA, MEM_READY, WRITE_COUNT
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM for the single-cycle core: combinational read, synchronous write,
// self-clearing after reset, with a host port that borrows cycles the core is not writing.
module data_mem_responder #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  data_mem_responder_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ready_q;
  logic                  ack_q;
  logic [SIZE-1:0]       rdata_q;
  logic [CNT_WIDTH-1:0]  wcnt_q;
  logic [SIZE-1:0]       mem_q [DEPTH];

  logic                  run;
  logic                  core_we;
  logic                  host_acc;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_d;
  logic [SIZE-1:0]       mem_wdata_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign run      = (state_q == ST_RUN);
  assign core_we  = run && bus.ENABLE_W;
  // Host only gets a slot when the core is idle and the previous ack has retired.
  assign host_acc = run && bus.HOST_REQ && !bus.ENABLE_W && !ack_q;

  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = bus.ADDR_RAM;
    mem_wdata_d = bus.Q_W;
    if (RESET) begin
      mem_we_d = 1'b0;
    end else if (!run) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = clr_cnt_q;
      mem_wdata_d = '0;
    end else if (core_we) begin
      mem_we_d = 1'b1;
    end else if (host_acc && bus.HOST_WE) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = bus.HOST_ADDR;
      mem_wdata_d = bus.HOST_WDATA;
    end
  end

  // Array storage carries no reset; the sweep clears it.
  always_ff @(posedge CLK) begin
    if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (&clr_cnt_q) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_we) wcnt_q <= sat_inc(wcnt_q);
          if (host_acc) begin
            ack_q <= 1'b1;
            if (!bus.HOST_WE) rdata_q <= mem_q[bus.HOST_ADDR];
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign bus.Q_RAM       = run ? mem_q[bus.ADDR_RAM] : '0;
  assign bus.HOST_ACK    = ack_q;
  assign bus.HOST_RDATA  = rdata_q;
  assign bus.MEM_READY   = ready_q;
  assign bus.WRITE_COUNT = wcnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at ADDR_WIDTH=4, SIZE=32, CNT_WIDTH=2.
module tb_data_mem_responder;
  localparam int SIZE = 32;
  localparam int AW   = 4;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  data_mem_responder_if #(.SIZE(SIZE), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  data_mem_responder #(.SIZE(SIZE), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds a host request until ACK (bounded); returns read data and edge count.
  task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [SIZE-1:0] wd,
                         output logic [SIZE-1:0] rd, output int n);
    bus.HOST_REQ   = 1'b1;
    bus.HOST_WE    = we;
    bus.HOST_ADDR  = addr;
    bus.HOST_WDATA = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.HOST_ACK && n < 40);
    if (!bus.HOST_ACK) chk("host_op_timeout", 64'(n), 64'(0));
    rd = bus.HOST_RDATA;
    bus.HOST_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE-1:0] rd;
    int n;
    int ack_seen;
    int nz_seen;
    logic [3:0] exp_cnt [5];
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd2; exp_cnt[2] = 4'd3; exp_cnt[3] = 4'd3; exp_cnt[4] = 4'd3;

    bus.ADDR_RAM = '0; bus.Q_W = '0; bus.ENABLE_W = 1'b0;
    bus.HOST_REQ = 1'b0; bus.HOST_WE = 1'b0; bus.HOST_ADDR = '0; bus.HOST_WDATA = '0;

    tick(); tick();
    chk("rst_ready", 64'(bus.MEM_READY), 64'(0));
    chk("rst_ack", 64'(bus.HOST_ACK), 64'(0));
    chk("rst_rdata", 64'(bus.HOST_RDATA), 64'(0));
    chk("rst_wcnt", 64'(bus.WRITE_COUNT), 64'(0));
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.MEM_READY && n < 40);
    chk("first_sweep_len", 64'(n), 64'(16));

    // Preload then reset: the sweep must wipe it and hold off the host.
    host_op(1'b1, 4'd5, 32'hDEAD, rd, n);
    bus.ADDR_RAM = 4'd5; #1;
    chk("preload_rd", 64'(bus.Q_RAM), 64'(32'hDEAD));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 4'd5;
    ack_seen = 0; nz_seen = 0;
    for (int i = 1; i <= 16; i++) begin
      if (bus.Q_RAM !== '0) nz_seen++;
      tick();
      if (bus.HOST_ACK) ack_seen++;
      if (i == 15) chk("clr_ready_15", 64'(bus.MEM_READY), 64'(0));
      if (i == 16) chk("clr_ready_16", 64'(bus.MEM_READY), 64'(1));
    end
    chk("clr_no_ack", 64'(ack_seen), 64'(0));
    chk("clr_qram_forced", 64'(nz_seen), 64'(0));
    chk("clr_addr5", 64'(bus.Q_RAM), 64'(0));
    tick();
    chk("post_clr_ack", 64'(bus.HOST_ACK), 64'(1));
    chk("post_clr_rdata", 64'(bus.HOST_RDATA), 64'(0));
    bus.HOST_REQ = 1'b0;
    tick();

    // Core write: old data visible until the edge.
    bus.ADDR_RAM = 4'd3; bus.Q_W = 32'h12345678; bus.ENABLE_W = 1'b1; #1;
    chk("cw_old", 64'(bus.Q_RAM), 64'(0));
    tick();
    bus.ENABLE_W = 1'b0; #1;
    chk("cw_new", 64'(bus.Q_RAM), 64'(32'h12345678));
    chk("cw_cnt", 64'(bus.WRITE_COUNT), 64'(1));

    // Collision: core writes for 3 edges, host write must wait.
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b1; bus.HOST_ADDR = 4'd7; bus.HOST_WDATA = 32'hA5A5A5A5;
    bus.ADDR_RAM = 4'd0; bus.Q_W = 32'h11; bus.ENABLE_W = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.HOST_ACK) ack_seen++;
    end
    chk("col_no_ack", 64'(ack_seen), 64'(0));
    bus.ENABLE_W = 1'b0; bus.ADDR_RAM = 4'd7; #1;
    chk("col_not_written", 64'(bus.Q_RAM), 64'(0));
    tick();
    chk("col_ack", 64'(bus.HOST_ACK), 64'(1));
    bus.HOST_REQ = 1'b0;
    chk("col_mem7", 64'(bus.Q_RAM), 64'(32'hA5A5A5A5));
    chk("col_cnt_sat", 64'(bus.WRITE_COUNT), 64'(3));
    bus.ADDR_RAM = 4'd0; #1;
    chk("col_core_mem0", 64'(bus.Q_RAM), 64'(32'h11));

    // Host read-back with REQ held: ack every second edge.
    bus.ADDR_RAM = 4'd2; bus.Q_W = 32'hCAFEF00D; bus.ENABLE_W = 1'b1;
    tick();
    bus.ENABLE_W = 1'b0;
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b0; bus.HOST_ADDR = 4'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rb_ack_%0d", i), 64'(bus.HOST_ACK), 64'((i % 2) == 0));
      if (i == 0) chk("rb_rdata", 64'(bus.HOST_RDATA), 64'(32'hCAFEF00D));
    end
    bus.HOST_REQ = 1'b0;
    tick();

    // Reset in the ACK cycle of an accepted host write.
    bus.HOST_REQ = 1'b1; bus.HOST_WE = 1'b1; bus.HOST_ADDR = 4'd9; bus.HOST_WDATA = 32'h55;
    tick();
    chk("mr_ack", 64'(bus.HOST_ACK), 64'(1));
    rst = 1'b1; bus.HOST_REQ = 1'b0;
    tick();
    chk("mr_ack0", 64'(bus.HOST_ACK), 64'(0));
    chk("mr_rdata0", 64'(bus.HOST_RDATA), 64'(0));
    chk("mr_wcnt0", 64'(bus.WRITE_COUNT), 64'(0));
    chk("mr_ready0", 64'(bus.MEM_READY), 64'(0));
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("mr_ready_15", 64'(bus.MEM_READY), 64'(0));
      if (i == 16) chk("mr_ready_16", 64'(bus.MEM_READY), 64'(1));
    end
    for (int a = 0; a < 16; a++) begin
      bus.ADDR_RAM = 4'(a); #1;
      chk($sformatf("mr_zero_%0d", a), 64'(bus.Q_RAM), 64'(0));
    end

    // Counter saturation over 5 core writes.
    bus.ENABLE_W = 1'b1; bus.Q_W = 32'h77;
    for (int i = 0; i < 5; i++) begin
      bus.ADDR_RAM = 4'(i);
      tick();
      chk($sformatf("sat_%0d", i), 64'(bus.WRITE_COUNT), 64'(exp_cnt[i]));
    end
    bus.ENABLE_W = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-cycle core's RAM interface. The core drives ADDR_RAM, Q_W and ENABLE_W; this block returns Q_RAM.
- Word-addressed storage of 2^ADDR_WIDTH words: synchronous write, combinational read, so the single-cycle datapath sees load data in the same cycle.
- After reset it clears itself with an internal sweep.
- A secondary host port (testbench/loader) uses a REQ/ACK handshake to preload or dump memory. It only borrows cycles in which the core is not writing.

Parameters:
- SIZE, 32, data word width in bits.
- ADDR_WIDTH, 10, word-address width; depth DEPTH = 2^ADDR_WIDTH.
- CNT_WIDTH, 16, width of the core write counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous reset, active-high.
- ADDR_RAM  in  ADDR_WIDTH  core word address (read and write).
- Q_W  in  SIZE  core write data.
- ENABLE_W  in  1  core write enable.
- Q_RAM  out  SIZE  core read data, combinational mem[ADDR_RAM].
- HOST_REQ  in  1  host request; held high until HOST_ACK.
- HOST_WE  in  1  host op: 1 = write, 0 = read; stable while HOST_REQ is high.
- HOST_ADDR  in  ADDR_WIDTH  host word address; stable while HOST_REQ is high.
- HOST_WDATA  in  SIZE  host write data; stable while HOST_REQ is high.
- HOST_ACK  out  1  one-cycle completion pulse.
- HOST_RDATA  out  SIZE  registered host read data; valid in the HOST_ACK cycle, held until the next host read.
- MEM_READY  out  1  high once the clear sweep is complete.
- WRITE_COUNT  out  CNT_WIDTH  saturating count of accepted core writes.

Behaviour:

Reset (RESET=1 at an edge):
- State becomes CLEAR, clear counter = 0.
- MEM_READY=0, HOST_ACK=0, HOST_RDATA=0, WRITE_COUNT=0.
- Array contents are not touched by reset itself.
- Reset asserted at any time (mid-clear, mid-run, or during a pending host request) restarts the sweep. Any in-flight host request is dropped; the host re-issues it.

CLEAR state:
- At each edge with RESET=0, write 0 to mem[clr_cnt], then clr_cnt++.
- The edge that clears address DEPTH-1 moves the state to RUN. MEM_READY=1 from that edge on.
- MEM_READY therefore rises exactly DEPTH edges after the first edge with RESET low.
- While in CLEAR:
  - Q_RAM is forced to 0.
  - Core writes are ignored and not counted.
  - HOST_REQ is ignored; HOST_ACK stays 0.

RUN state, core port:
- Q_RAM = mem[ADDR_RAM], combinational. No read latency.
- ENABLE_W=1 at an edge writes Q_W to mem[ADDR_RAM].
- A read of the address being written returns the old data until the edge, and the new data afterwards.
- The core port always has priority and never stalls.
- Each accepted core write does WRITE_COUNT++, saturating at 2^CNT_WIDTH-1 (no wrap).

RUN state, host port:
- A request is accepted at an edge when HOST_REQ=1, ENABLE_W=0 and HOST_ACK=0.
  - Write (HOST_WE=1): mem[HOST_ADDR] <= HOST_WDATA.
  - Read (HOST_WE=0): HOST_RDATA <= mem[HOST_ADDR] (pre-edge contents).
- HOST_ACK=1 for exactly the cycle following acceptance, then forced to 0.
- Back-to-back requests therefore complete at most every 2 cycles.
- If ENABLE_W=1, acceptance is deferred, with no ack and no side effect. A host can starve while the core writes continuously; this is the intended behaviour.
- Host writes are not counted in WRITE_COUNT.
- A host write becomes visible on Q_RAM the cycle after acceptance.

Other rules:
- Address arithmetic is ADDR_WIDTH bits; all addresses are valid; there is no out-of-range handling.
- HOST_REQ dropped before HOST_ACK: behaviour is only defined if it is dropped before acceptance. A request that has already been accepted still completes and acks.

Test Plan (ADDR_WIDTH=4, SIZE=32, CNT_WIDTH=2 unless noted):
- Reset clear: preload mem[5]=0xDEAD via host, then assert RESET for 1 cycle and release -> MEM_READY low for 16 cycles and high after the 16th edge; ADDR_RAM=5 reads 0x0; host REQ during the clear gets no ACK until after MEM_READY.
- Core write/read: ENABLE_W=1, ADDR_RAM=3, Q_W=0x12345678 for one cycle -> Q_RAM at ADDR_RAM=3 shows the old value during the write cycle and 0x12345678 after the edge; WRITE_COUNT=1.
- Host vs core collision: HOST_REQ write of addr 7 = 0xA5A5A5A5 while ENABLE_W=1 for 3 cycles -> no ACK during those 3 cycles; ACK in the cycle after the first ENABLE_W=0 edge; mem[7] then reads 0xA5A5A5A5 via the core port.
- Host read-back: core writes addr 2 = 0xCAFEF00D, then host read of addr 2 -> HOST_ACK pulses for 1 cycle with HOST_RDATA=0xCAFEF00D; with HOST_REQ held continuously, ACKs occur every 2nd cycle.
- Counter saturation: 5 core writes -> WRITE_COUNT goes 1, 2, 3, 3, 3.
- Reset mid-run: host request accepted, then RESET=1 in the ACK cycle -> after the next edge HOST_ACK=0, HOST_RDATA=0, WRITE_COUNT=0, MEM_READY=0; full 16-cycle sweep repeats and all addresses read 0.
